// File: rtl/pipeline_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_pkg
// Shared constants for the pipeline hazard/stall controller.
//   ST_RUN / ST_MEM_WAIT : FSM state encoding used by pipeline_ctrl
//   TIMEOUT_DEF          : default MEM_WAIT cycle count before err_o sets
//   CNT_W_DEF            : default width of the frozen-cycle counter
// Optional feature macro: PIPELINE_CTRL_PERF_EN (see pipeline_ctrl.sv).
// ----------------------------------------------------------------------------
package pipeline_pkg;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    localparam int TIMEOUT_DEF = 16;
    localparam int CNT_W_DEF   = 32;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundles the hazard inputs and stage-control outputs between the pipeline
// datapath (master) and pipeline_ctrl (slave).
//   *_i signals : driven by the datapath (master), read by the controller
//   *_o signals : driven by the controller (slave), read by the datapath
//   stall_cnt_o : present only when PIPELINE_CTRL_PERF_EN is defined
// ----------------------------------------------------------------------------
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);

    logic       IDEX_MemRead_i;
    logic [4:0] IDEX_RTaddr_i;
    logic [4:0] IFID_RSaddr_i;
    logic [4:0] IFID_RTaddr_i;
    logic       branch_taken_i;
    logic       mem_req_i;
    logic       mem_ack_i;

    logic       PC_write_o;
    logic       IFID_write_o;
    logic       IDEX_stall_o;
    logic       EXMEM_stall_o;
    logic       MEMWB_stall_o;
    logic       IDEX_bubble_o;
    logic       IFID_flush_o;
    logic       err_o;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_o;
`endif

    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("pipeline_ctrl_if: CNT_W must be >= 1");
    end

    modport master (
        output IDEX_MemRead_i, IDEX_RTaddr_i, IFID_RSaddr_i, IFID_RTaddr_i,
               branch_taken_i, mem_req_i, mem_ack_i,
        input  PC_write_o, IFID_write_o, IDEX_stall_o, EXMEM_stall_o,
               MEMWB_stall_o, IDEX_bubble_o, IFID_flush_o, err_o
`ifdef PIPELINE_CTRL_PERF_EN
               , stall_cnt_o
`endif
    );

    modport slave (
        input  IDEX_MemRead_i, IDEX_RTaddr_i, IFID_RSaddr_i, IFID_RTaddr_i,
               branch_taken_i, mem_req_i, mem_ack_i,
        output PC_write_o, IFID_write_o, IDEX_stall_o, EXMEM_stall_o,
               MEMWB_stall_o, IDEX_bubble_o, IFID_flush_o, err_o
`ifdef PIPELINE_CTRL_PERF_EN
               , stall_cnt_o
`endif
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
// Load-use comparator: flags when the load in EX writes a register that the
// instruction in ID reads. Register 0 is hard-wired and never a hazard.
//   i_memread  : EX instruction is a load
//   i_idex_rt  : load destination register in EX
//   i_ifid_rs  : first source register in ID
//   i_ifid_rt  : second source register in ID
//   o_load_use : load-use hazard present this cycle
// ----------------------------------------------------------------------------
module hazard_detect (
    input  logic       i_memread,
    input  logic [4:0] i_idex_rt,
    input  logic [4:0] i_ifid_rs,
    input  logic [4:0] i_ifid_rt,
    output logic       o_load_use
);

    assign o_load_use = i_memread & (i_idex_rt != 5'd0) &
                        ((i_idex_rt == i_ifid_rs) | (i_idex_rt == i_ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
// Pipeline stall/flush controller: freezes the whole pipe while a MEM-stage
// access is outstanding, inserts one bubble on a load-use hazard, and flushes
// IF/ID on a taken branch (deferred if the branch coincides with a stall).
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   bus   : pipeline_ctrl_if.slave (hazard inputs, stage-control outputs)
// Optional: PIPELINE_CTRL_PERF_EN adds bus.stall_cnt_o, a wrapping count of
// cycles with freeze or load_use.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_RUN      | normal flow; a memory request without ack freezes and waits
// ST_MEM_WAIT | memory access outstanding; frozen until mem_ack_i
// ----------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    pipeline_ctrl_if.slave bus
);

    localparam int              WC_W  = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] TO_L  = WC_W'(TIMEOUT);
    localparam logic [WC_W-1:0] TO_M1 = WC_W'(TIMEOUT - 1);

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("pipeline_ctrl: TIMEOUT must be >= 1");
    end
    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("pipeline_ctrl: CNT_W must be >= 1");
    end

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic            r_flush_pend;
    logic            r_err;
    logic [WC_W-1:0] r_wait_cnt;
    logic            w_freeze;
    logic            w_load_use;
    logic            w_flush;
    logic            w_waiting;

    hazard_detect u_hazard_detect (
        .i_memread  (bus.IDEX_MemRead_i),
        .i_idex_rt  (bus.IDEX_RTaddr_i),
        .i_ifid_rs  (bus.IFID_RSaddr_i),
        .i_ifid_rt  (bus.IFID_RTaddr_i),
        .o_load_use (w_load_use)
    );

    assign w_freeze  = ((r_state == ST_RUN) & bus.mem_req_i & ~bus.mem_ack_i) |
                       ((r_state == ST_MEM_WAIT) & ~bus.mem_ack_i);
    assign w_flush   = ~w_freeze & ~w_load_use & (bus.branch_taken_i | r_flush_pend);
    // A MEM_WAIT cycle that is still unacknowledged counts toward the timeout.
    assign w_waiting = (r_state == ST_MEM_WAIT) & ~bus.mem_ack_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:      if (bus.mem_req_i & ~bus.mem_ack_i) w_state_nxt = ST_MEM_WAIT;
            ST_MEM_WAIT: if (bus.mem_ack_i)                  w_state_nxt = ST_RUN;
            default:     w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= ST_RUN;
            r_flush_pend <= 1'b0;
            r_wait_cnt   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // Branch seen while the pipe cannot flush is remembered until it can.
            if (w_flush)
                r_flush_pend <= 1'b0;
            else if (bus.branch_taken_i & (w_freeze | w_load_use))
                r_flush_pend <= 1'b1;

            if ((r_state == ST_RUN) && (w_state_nxt == ST_MEM_WAIT))
                r_wait_cnt <= '0;
            else if (w_waiting && (r_wait_cnt != TO_L))
                r_wait_cnt <= r_wait_cnt + 1'b1;

            // Set on the edge where the counter arrives at TIMEOUT; sticky.
            if (w_waiting && (r_wait_cnt == TO_M1))
                r_err <= 1'b1;
        end
    end

    always_comb begin
        bus.PC_write_o    = 1'b1;
        bus.IFID_write_o  = 1'b1;
        bus.IDEX_stall_o  = 1'b0;
        bus.EXMEM_stall_o = 1'b0;
        bus.MEMWB_stall_o = 1'b0;
        bus.IDEX_bubble_o = 1'b0;
        bus.IFID_flush_o  = 1'b0;
        if (w_freeze) begin
            bus.PC_write_o    = 1'b0;
            bus.IFID_write_o  = 1'b0;
            bus.IDEX_stall_o  = 1'b1;
            bus.EXMEM_stall_o = 1'b1;
            bus.MEMWB_stall_o = 1'b1;
        end else if (w_load_use) begin
            bus.PC_write_o    = 1'b0;
            bus.IFID_write_o  = 1'b0;
            bus.IDEX_bubble_o = 1'b1;
        end else begin
            bus.IFID_flush_o  = w_flush;
        end
    end

    assign bus.err_o = r_err;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            r_stall_cnt <= '0;
        else if (w_freeze | w_load_use)
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign bus.stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed-vector bench for pipeline_ctrl. The driver applies one vector per
// clock shortly after the rising edge and queues the hand-computed outputs;
// a monitor on the falling edge pops and compares.
// Output bit order: {PC_write, IFID_write, IDEX_stall, EXMEM_stall,
//                    MEMWB_stall, IDEX_bubble, IFID_flush, err}
// ----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;

    localparam logic [7:0] NORM = 8'b1100_0000;
    localparam logic [7:0] NFL  = 8'b1100_0010;
    localparam logic [7:0] FRZ  = 8'b0011_1000;
    localparam logic [7:0] LU   = 8'b0000_0100;
    localparam logic [7:0] ERR  = 8'b0000_0001;

    typedef struct {
        logic [7:0]       bits;
        logic [CNT_W-1:0] cnt;
        string            name;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic [CNT_W-1:0] m_cnt = '0;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        bus.IDEX_MemRead_i = 1'b0;
        bus.IDEX_RTaddr_i  = 5'd0;
        bus.IFID_RSaddr_i  = 5'd0;
        bus.IFID_RTaddr_i  = 5'd0;
        bus.branch_taken_i = 1'b0;
        bus.mem_req_i      = 1'b0;
        bus.mem_ack_i      = 1'b0;
    end

    task automatic vec(input logic rst, input logic mr, input logic [4:0] rt,
                       input logic [4:0] rs, input logic [4:0] rt2,
                       input logic br, input logic req, input logic ack,
                       input logic [7:0] exp_bits, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n              = rst;
        bus.IDEX_MemRead_i = mr;
        bus.IDEX_RTaddr_i  = rt;
        bus.IFID_RSaddr_i  = rs;
        bus.IFID_RTaddr_i  = rt2;
        bus.branch_taken_i = br;
        bus.mem_req_i      = req;
        bus.mem_ack_i      = ack;
        if (!rst) m_cnt = '0;
        e.bits = exp_bits;
        e.cnt  = m_cnt;
        e.name = name;
        q.push_back(e);
        if (rst && (exp_bits[5] || exp_bits[2])) m_cnt = m_cnt + 1'b1;
    endtask

    task automatic idle(input logic [7:0] exp_bits, input string name);
        vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp_bits, name);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t       e;
            logic [7:0] act;
            logic       ok;
            e   = q.pop_front();
            act = {bus.PC_write_o, bus.IFID_write_o, bus.IDEX_stall_o,
                   bus.EXMEM_stall_o, bus.MEMWB_stall_o, bus.IDEX_bubble_o,
                   bus.IFID_flush_o, bus.err_o};
            ok  = (act === e.bits);
`ifdef PIPELINE_CTRL_PERF_EN
            if (bus.stall_cnt_o !== e.cnt) ok = 1'b0;
            if (!ok)
                $display("FAIL %s: outputs %b cnt %0d, expected %b cnt %0d",
                         e.name, act, bus.stall_cnt_o, e.bits, e.cnt);
`else
            if (!ok)
                $display("FAIL %s: outputs %b, expected %b", e.name, act, e.bits);
`endif
            vectors = vectors + 1;
            if (!ok) miscompares = miscompares + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //   rst  mr    rt     rs     rt2    br    req   ack
        vec(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM, "reset");
        idle(NORM, "idle");
        vec(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, LU,   "lu_rs");
        idle(NORM, "lu_next");
        vec(1'b1, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, LU,   "lu_rt");
        vec(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM, "lu_r0");
        vec(1'b1, 1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, NORM, "no_load");
        vec(1'b1, 1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0, 1'b0, NORM, "lu_miss");
        vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, NFL,  "branch");
        // three frozen cycles, advance on ack
        vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ,  "frz1");
        vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ,  "frz2");
        vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ,  "frz3");
        vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, NORM, "ack_adv");
        idle(NORM, "back_run");
        // request and ack together: no freeze, stays in RUN
        vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, NORM, "req_ack");
        idle(NORM, "req_ack_run");
        // branch + load_use during a 2-cycle freeze: flush deferred to ack
        vec(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, FRZ,  "frz_br");
        vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ,  "frz_br2");
        vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, NFL,  "flush_ack");
        idle(NORM, "flush_clr");
        // branch during load_use: flush in the following cycle
        vec(1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, LU,   "lu_br");
        idle(NFL,  "lu_flush");
        idle(NORM, "lu_flush_clr");
        // timeout: enter MEM_WAIT, then TIMEOUT unacked MEM_WAIT cycles
        vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ,  "to_enter");
        for (int j = 1; j <= TIMEOUT; j++)
            vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ, $sformatf("to_wait%0d", j));
        vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ | ERR,  "to_err");
        vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, NORM | ERR, "to_ack");
        idle(NORM | ERR, "err_sticky");
        // reset mid-wait with a flush pending
        vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ | ERR,  "mw_enter");
        vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, FRZ | ERR,  "mw_br");
        vec(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM,       "rst_mid");
        idle(NORM, "post_rst");
        // 2 load_use + 3 frozen cycles -> counter 5
        vec(1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, LU,   "perf_lu1");
        vec(1'b1, 1'b1, 5'd4, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0, LU,   "perf_lu2");
        vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ,  "perf_f1");
        vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ,  "perf_f2");
        vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ,  "perf_f3");
        vec(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, NORM, "perf_ack");
        idle(NORM, "perf_cnt5");

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            $display("FAIL drain: %0d vectors unchecked, expected 0", q.size());
            miscompares = miscompares + 1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the number of MEM_WAIT cycles after which err_o sets.
REQ-002 SHALL have parameter CNT_W, default 32, the width of stall_cnt_o.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port IDEX_MemRead_i, input, 1 bit: the instruction in EX is a load.
REQ-006 SHALL have port IDEX_RTaddr_i, input, 5 bits: load destination register in EX.
REQ-007 SHALL have ports IFID_RSaddr_i and IFID_RTaddr_i, input, 5 bits each: source registers in ID.
REQ-008 SHALL have port branch_taken_i, input, 1 bit: branch resolved taken in ID this cycle.
REQ-009 SHALL have ports mem_req_i and mem_ack_i, input, 1 bit each: MEM-stage data access request and completion.
REQ-010 SHALL have ports PC_write_o and IFID_write_o, output, 1 bit each: register enables, 1 = advance.
REQ-011 SHALL have ports IDEX_stall_o, EXMEM_stall_o and MEMWB_stall_o, output, 1 bit each: hold the stage register, 1 = hold.
REQ-012 SHALL have port IDEX_bubble_o, output, 1 bit: zero the ID/EX control bits at the next edge.
REQ-013 SHALL have port IFID_flush_o, output, 1 bit: clear IF/ID at the next edge.
REQ-014 SHALL have port err_o, output, 1 bit: sticky memory-timeout flag.
REQ-015 SHALL have port stall_cnt_o, output, CNT_W bits: count of frozen cycles (present only with the macro in REQ-032).

Function
REQ-016 SHALL implement a two-state FSM: RUN and MEM_WAIT.
REQ-017 SHALL drive all control outputs combinationally from the current state and current inputs, with zero-cycle latency.
REQ-018 SHALL define freeze = (state==RUN & mem_req_i & ~mem_ack_i) | (state==MEM_WAIT & ~mem_ack_i).
REQ-019 During freeze SHALL drive PC_write_o=0, IFID_write_o=0, IDEX_stall_o=1, EXMEM_stall_o=1, MEMWB_stall_o=1, IDEX_bubble_o=0 and IFID_flush_o=0.
REQ-020 SHALL transition RUN->MEM_WAIT when mem_req_i=1 and mem_ack_i=0; when both are 1 in RUN it SHALL stay in RUN with no freeze.
REQ-021 SHALL transition MEM_WAIT->RUN in the cycle mem_ack_i=1; that cycle is not frozen, so the pipeline advances at that edge.
REQ-022 SHALL define load_use = IDEX_MemRead_i & (IDEX_RTaddr_i!=0) & (IDEX_RTaddr_i==IFID_RSaddr_i | IDEX_RTaddr_i==IFID_RTaddr_i).
REQ-023 When ~freeze and load_use, SHALL drive PC_write_o=0, IFID_write_o=0 and IDEX_bubble_o=1 for exactly that cycle; EX/MEM and MEM/WB advance.
REQ-024 Priority SHALL be freeze > load_use > flush; load_use SHALL be ignored during freeze.
REQ-025 SHALL drive IFID_flush_o = ~freeze & ~load_use & (branch_taken_i | flush_pend).
REQ-026 SHALL set flush_pend when branch_taken_i=1 during freeze or load_use, and clear it in the cycle IFID_flush_o=1.
REQ-027 SHALL hold a wait counter cleared on entry to MEM_WAIT and incremented each MEM_WAIT cycle, saturating at TIMEOUT.
REQ-028 SHALL set err_o when the wait counter reaches TIMEOUT; err_o clears only on reset, and the FSM keeps waiting for mem_ack_i.
REQ-029 With every stall condition false, SHALL drive PC_write_o=1 and IFID_write_o=1 and all other control outputs 0.

Reset
REQ-030 rst_i=0 SHALL immediately force state=RUN, flush_pend=0, wait counter=0, err_o=0 and stall_cnt_o=0, independent of clk_i.
REQ-031 Reset asserted mid-MEM_WAIT SHALL abandon the wait; after release the block SHALL be in RUN with no pending flush.

Configuration
REQ-032 With PIPELINE_CTRL_PERF_EN defined, SHALL provide stall_cnt_o, incremented by 1 each cycle with freeze or load_use, wrapping modulo 2^CNT_W; without the macro, the port and counter SHALL be absent and the other outputs identical.

Structure
REQ-033 SHALL place the FSM state encoding (RUN=1'b0, MEM_WAIT=1'b1) and the default TIMEOUT constant in shared package pipeline_pkg.
REQ-034 SHALL factor the load_use comparator into sub-module hazard_detect; the FSM, flush_pend, counters and output muxing SHALL remain in pipeline_ctrl.

Verification
REQ-035 Load EX RT=5, ID RS=5 -> one cycle with PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1; next cycle normal. RT=0 -> no stall.
REQ-036 mem_req_i=1, mem_ack_i delayed 3 cycles -> 3 frozen cycles; advance in the ack cycle; state back to RUN.
REQ-037 mem_req_i=1 and mem_ack_i=1 in the same cycle -> no freeze, state stays RUN.
REQ-038 branch_taken_i=1 in the first cycle of a 2-cycle freeze -> IFID_flush_o=1 exactly in the ack cycle, then 0.
REQ-039 mem_ack_i held 0 for TIMEOUT cycles -> err_o=1 and stays 1 after ack; rst_i=0 mid-wait -> all outputs at reset values.
REQ-040 With PIPELINE_CTRL_PERF_EN: 2 load_use cycles plus a 3-cycle freeze -> stall_cnt_o=5.
